buton_pietoni: RTL and testbench

Pedestrian call unit driving the request side of the crossing controller. It synchronises and debounces the raw push-button, then latches one clean request. It holds that request on the `buton` line until the controller answers with pedestrian green on `semafor_pietoni`. Meanwhile it blinks a "wait" lamp and counts served requests.

---
 rtl/buton_pietoni.sv | 110 +++++++++++
 tb/tb_buton_pietoni.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/buton_pietoni.sv
// Pedestrian call unit: synchronises and debounces the push-button, latches one
// request on `buton` until pedestrian green, blinks a wait lamp, counts served calls.
module buton_pietoni #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_CYCLES    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buton_raw,
  input  logic       semafor_pietoni,
  output logic       buton,
  output logic       lampa_asteptare,
  output logic [7:0] nr_cereri
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CERERE = 2'd1;
  localparam logic [1:0] SERVIT = 2'd2;

  localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_CYCLES - 1);

  logic       sync1, sync2;
  logic       deb, deb_prev;
  logic [7:0] cnt_deb;
  logic [1:0] state, state_next;
  logic       blink;
  logic [7:0] cnt_blink;
  logic       press;

  // NOTE: two-flop synchroniser on the asynchronous button; sequential state
  // always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= buton_raw;
      sync2 <= sync1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb      <= 1'b0;
      deb_prev <= 1'b0;
      cnt_deb  <= 8'd0;
    end else begin
      deb_prev <= deb;
      if (sync2 != deb) begin
        if (cnt_deb == DEB_LAST) begin
          deb     <= sync2;
          cnt_deb <= 8'd0;
        end else begin
          cnt_deb <= cnt_deb + 8'd1;
        end
      end else begin
        cnt_deb <= 8'd0;
      end
    end
  end

  assign press = deb & ~deb_prev;

  // NOTE: next-state defaults to the current state before the case, so no
  // path leaves state_next unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (press && !semafor_pietoni) state_next = CERERE;
      CERERE:  if (semafor_pietoni)           state_next = SERVIT;
      SERVIT:  if (!semafor_pietoni)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Blink phase restarts on every entry to CERERE so the lamp always opens lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink     <= 1'b1;
      cnt_blink <= 8'd0;
    end else if (state_next != CERERE || state != CERERE) begin
      blink     <= 1'b1;
      cnt_blink <= 8'd0;
    end else if (cnt_blink == BLINK_LAST) begin
      blink     <= ~blink;
      cnt_blink <= 8'd0;
    end else begin
      cnt_blink <= cnt_blink + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nr_cereri <= 8'd0;
    end else if (state == CERERE && semafor_pietoni && nr_cereri != 8'hFF) begin
      nr_cereri <= nr_cereri + 8'd1;
    end
  end

  assign buton           = (state == CERERE);
  assign lampa_asteptare = (state == CERERE) & blink;

endmodule

// File: tb/tb_buton_pietoni.sv
// Directed bench for buton_pietoni: expected outputs are queued with each
// stimulus step and popped for comparison once the DUT has clocked.
module tb_buton_pietoni;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       buton_raw;
  logic       semafor_pietoni;
  logic       buton;
  logic       lampa_asteptare;
  logic [7:0] nr_cereri;

  typedef struct {
    string      tag;
    logic       b;
    logic       l;
    logic [7:0] n;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   served = 0;

  buton_pietoni #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .buton_raw       (buton_raw),
    .semafor_pietoni (semafor_pietoni),
    .buton           (buton),
    .lampa_asteptare (lampa_asteptare),
    .nr_cereri       (nr_cereri)
  );

  always #5 clk = ~clk;

  // Lamp level k cycles into CERERE with a half-period of 3.
  function automatic logic lamp_at(input int k);
    return ((k / 3) % 2) == 0;
  endfunction

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    tests++;
    assert (buton === e.b) else begin
      fails++;
      $error("FAIL %s buton observed %0b expected %0b", e.tag, buton, e.b);
    end
    tests++;
    assert (lampa_asteptare === e.l) else begin
      fails++;
      $error("FAIL %s lampa_asteptare observed %0b expected %0b", e.tag, lampa_asteptare, e.l);
    end
    tests++;
    assert (nr_cereri === e.n) else begin
      fails++;
      $error("FAIL %s nr_cereri observed %0d expected %0d", e.tag, nr_cereri, e.n);
    end
  endtask

  task automatic check_now(input string tag, input logic b, input logic l, input logic [7:0] n);
    sb.push_back('{tag, b, l, n});
    compare();
  endtask

  // Drive inputs, queue the outputs expected after the next rising edge, then check.
  task automatic step(input string tag, input logic raw, input logic sem,
                      input logic b, input logic l, input logic [7:0] n);
    buton_raw       = raw;
    semafor_pietoni = sem;
    sb.push_back('{tag, b, l, n});
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    rst_n           = 1'b0;
    buton_raw       = 1'b0;
    semafor_pietoni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;

    // Clean press: request appears after edge 7, lamp 1,1,1,0,0,0 repeating.
    for (int i = 1; i <= 6; i++) step("press_wait", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 12; k++) step("press_lamp", 1'b1, 1'b0, 1'b1, lamp_at(k), 8'd0);

    // Acknowledge: 10 green cycles, then back to IDLE.
    for (int i = 0; i < 10; i++) step("ack_green", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    step("ack_release", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 8; i++) step("ack_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    // Bounce 1,0,1,0 then stable 1: request exactly 7 edges after the stable 1.
    step("bounce", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    step("bounce", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    step("bounce", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    step("bounce", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    for (int i = 1; i <= 6; i++) step("bounce_wait", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
    step("bounce_req", 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);

    // Green arrives; a full debounced press during SERVIT must be ignored.
    step("servit_ack", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 14; i++) step("servit_rel", 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 12; i++) step("servit_press", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 5; i++)  step("servit_exit", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 8; i++)  step("servit_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);

    // Press in IDLE while green is shown: ignored, and not replayed once green drops.
    for (int i = 0; i < 12; i++) step("idle_green_press", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 5; i++)  step("idle_green_held", 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
    for (int i = 0; i < 8; i++)  step("idle_green_rel", 1'b0, 1'b0, 1'b0, 1'b0, 8'd2);

    // Saturation: 260 served requests in total.
    served = 2;
    while (served < 260) begin
      logic [7:0] n_before;
      logic [7:0] n_after;
      n_before = (served > 255) ? 8'd255 : 8'(served);
      served++;
      n_after  = (served > 255) ? 8'd255 : 8'(served);
      for (int i = 1; i <= 6; i++) step("sat_wait", 1'b1, 1'b0, 1'b0, 1'b0, n_before);
      step("sat_req", 1'b1, 1'b0, 1'b1, 1'b1, n_before);
      step("sat_ack", 1'b0, 1'b1, 1'b0, 1'b0, n_after);
      for (int i = 0; i < 7; i++) step("sat_idle", 1'b0, 1'b0, 1'b0, 1'b0, n_after);
    end

    // Reset while a request is pending with the button still held.
    for (int i = 1; i <= 6; i++) step("mid_wait", 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
    step("mid_req", 1'b1, 1'b0, 1'b1, 1'b1, 8'd255);
    rst_n = 1'b0;
    #1;
    check_now("mid_reset_async", 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    check_now("mid_reset_hold", 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) step("post_reset_wait", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 6; k++) step("post_reset_lamp", 1'b1, 1'b0, 1'b1, lamp_at(k), 8'd0);
    step("post_reset_ack", 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    step("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
